// File: rtl/riscv_mem_arbiter.sv
// Single-port memory arbiter between the RV32I fetch port and load/store port.
// Optional macro RISCV_ARB_RR_EN selects round-robin conflict resolution; otherwise data wins.
`timescale 1ns/1ps
module riscv_mem_arbiter #(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       TIMEOUT_CYC  = 255,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_inst_rd_en,
    input  logic [ADDR_W-1:0] i_inst_addr,
    output logic              o_instr_ready,
    output logic [DATA_W-1:0] o_instr_data,
    input  logic              i_data_rd_en_ma,
    input  logic              i_data_wr_en_ma,
    input  logic [1:0]        i_data_rd_en_ctrl,
    input  logic [ADDR_W-1:0] i_data_addr,
    input  logic [DATA_W-1:0] i_data_wr,
    output logic              o_data_ready,
    output logic [DATA_W-1:0] o_data_rd,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [1:0]        o_mem_size,
    input  logic              i_mem_ready,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_timeout
);

    localparam int unsigned      CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
    localparam logic [1:0]       SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        INSTR_XFER = 2'd1,
        DATA_XFER  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef RISCV_ARB_RR_EN
    // 1 = data side preferred on the next conflict
    logic              ptr_q, ptr_d;
`endif

    logic              data_req_c;
    logic              grant_data_c;
    logic              xfer_c;
    logic              timeout_c;
    logic              done_c;
    logic [DATA_W-1:0] rd_val_c;

    always_comb begin
        data_req_c = i_data_rd_en_ma | i_data_wr_en_ma;
`ifdef RISCV_ARB_RR_EN
        grant_data_c = data_req_c && (!i_inst_rd_en || ptr_q);
`else
        grant_data_c = data_req_c;
`endif
        xfer_c    = (state_q != IDLE);
        timeout_c = (TIMEOUT_CYC != 0) && xfer_c && !i_mem_ready && (cnt_q == CNT_MAX);
        done_c    = xfer_c && (i_mem_ready || timeout_c);
        rd_val_c  = timeout_c ? TIMEOUT_DATA : i_mem_rdata;
    end

    // Next-state and captured request fields
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
`ifdef RISCV_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_data_c) begin
                    state_d = DATA_XFER;
                    addr_d  = i_data_addr;
                    wdata_d = i_data_wr;
                    we_d    = i_data_wr_en_ma;
                    size_d  = (i_data_rd_en_ctrl == 2'b11) ? SIZE_WORD : i_data_rd_en_ctrl;
                    cnt_d   = '0;
`ifdef RISCV_ARB_RR_EN
                    ptr_d   = 1'b0;
`endif
                end else if (i_inst_rd_en) begin
                    state_d = INSTR_XFER;
                    addr_d  = i_inst_addr;
                    wdata_d = '0;
                    we_d    = 1'b0;
                    size_d  = SIZE_WORD;
                    cnt_d   = '0;
`ifdef RISCV_ARB_RR_EN
                    ptr_d   = 1'b1;
`endif
                end
            end
            default: begin
                if (done_c) begin
                    state_d = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            cnt_q   <= '0;
`ifdef RISCV_ARB_RR_EN
            ptr_q   <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
`ifdef RISCV_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Completion is combinational so the core sees ready in the memory's ready cycle
    assign o_mem_req     = xfer_c;
    assign o_mem_we      = we_q;
    assign o_mem_addr    = addr_q;
    assign o_mem_wdata   = wdata_q;
    assign o_mem_size    = size_q;
    assign o_instr_ready = done_c && (state_q == INSTR_XFER);
    assign o_data_ready  = done_c && (state_q == DATA_XFER);
    assign o_instr_data  = o_instr_ready ? rd_val_c : '0;
    assign o_data_rd     = o_data_ready ? rd_val_c : '0;
    assign o_timeout     = timeout_c;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: fetch, store, conflicts, watchdog and async reset.
`timescale 1ns/1ps
module tb_riscv_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_inst_rd_en;
    logic [31:0] i_inst_addr;
    logic        o_instr_ready;
    logic [31:0] o_instr_data;
    logic        i_data_rd_en_ma;
    logic        i_data_wr_en_ma;
    logic [1:0]  i_data_rd_en_ctrl;
    logic [31:0] i_data_addr;
    logic [31:0] i_data_wr;
    logic        o_data_ready;
    logic [31:0] o_data_rd;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [1:0]  o_mem_size;
    logic        i_mem_ready;
    logic [31:0] i_mem_rdata;
    logic        o_timeout;

    int n_vec = 0;
    int n_err = 0;

    riscv_mem_arbiter #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_inst_rd_en(i_inst_rd_en), .i_inst_addr(i_inst_addr),
        .o_instr_ready(o_instr_ready), .o_instr_data(o_instr_data),
        .i_data_rd_en_ma(i_data_rd_en_ma), .i_data_wr_en_ma(i_data_wr_en_ma),
        .i_data_rd_en_ctrl(i_data_rd_en_ctrl), .i_data_addr(i_data_addr),
        .i_data_wr(i_data_wr), .o_data_ready(o_data_ready), .o_data_rd(o_data_rd),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_size(o_mem_size),
        .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata), .o_timeout(o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n = 1'b0;
        i_inst_rd_en = 1'b0; i_inst_addr = '0;
        i_data_rd_en_ma = 1'b0; i_data_wr_en_ma = 1'b0; i_data_rd_en_ctrl = 2'b10;
        i_data_addr = '0; i_data_wr = '0;
        i_mem_ready = 1'b0; i_mem_rdata = '0;
        #1;
        n_vec++; if (o_mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %0h want 0", o_mem_req); end
        n_vec++; if ({o_instr_ready, o_data_ready, o_timeout} !== 3'b000) begin n_err++; $display("FAIL rst_ready: got %b want 000", {o_instr_ready, o_data_ready, o_timeout}); end
        n_vec++; if ({o_mem_we, o_mem_size, o_mem_addr, o_mem_wdata} !== 67'd0) begin n_err++; $display("FAIL rst_fields: got we=%b size=%b addr=%h wdata=%h want zeros", o_mem_we, o_mem_size, o_mem_addr, o_mem_wdata); end
        n_vec++; if ({o_instr_data, o_data_rd} !== 64'd0) begin n_err++; $display("FAIL rst_data: got %h %h want 0 0", o_instr_data, o_data_rd); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_arbitration;
        logic [1:0]  got;
        logic [1:0]  exp;
        logic [31:0] exp_addr;
        @(negedge clk);
        i_inst_rd_en = 1'b1; i_inst_addr = 32'h0000_0200;
        i_data_rd_en_ma = 1'b1; i_data_addr = 32'h0000_0300; i_data_rd_en_ctrl = 2'b10;
        for (int i = 0; i < 4; i++) begin
`ifdef RISCV_ARB_RR_EN
            exp = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp = 2'b10;
`endif
            exp_addr = (exp == 2'b10) ? 32'h0000_0300 : 32'h0000_0200;
            @(negedge clk);
            n_vec++; if (o_mem_addr !== exp_addr) begin n_err++; $display("FAIL arb_addr%0d: got %h want %h", i, o_mem_addr, exp_addr); end
            i_mem_ready = 1'b1; i_mem_rdata = 32'h0000_1000 + i;
            #1;
            got = {o_data_ready, o_instr_ready};
            n_vec++; if (got !== exp) begin n_err++; $display("FAIL arb_grant%0d: got %b want %b", i, got, exp); end
            @(negedge clk);
            i_mem_ready = 1'b0;
        end
        i_inst_rd_en = 1'b0; i_data_rd_en_ma = 1'b0;
    endtask

    task automatic test_fetch;
        @(negedge clk);
        i_inst_rd_en = 1'b1; i_inst_addr = 32'h0000_0040;
        @(negedge clk);
        n_vec++; if ({o_mem_req, o_mem_we, o_mem_size} !== 4'b1010) begin n_err++; $display("FAIL fetch_req: got req/we/size %b want 1010", {o_mem_req, o_mem_we, o_mem_size}); end
        n_vec++; if (o_mem_addr !== 32'h0000_0040) begin n_err++; $display("FAIL fetch_addr: got %h want 00000040", o_mem_addr); end
        n_vec++; if (o_instr_ready !== 1'b0) begin n_err++; $display("FAIL fetch_early: got %0h want 0", o_instr_ready); end
        i_inst_addr = 32'h0000_0044;
        @(negedge clk);
        n_vec++; if (o_mem_addr !== 32'h0000_0040) begin n_err++; $display("FAIL fetch_hold: got %h want 00000040", o_mem_addr); end
        i_mem_ready = 1'b1; i_mem_rdata = 32'h00A1_0093;
        #1;
        n_vec++; if ({o_instr_ready, o_data_ready} !== 2'b10) begin n_err++; $display("FAIL fetch_ready: got %b want 10", {o_instr_ready, o_data_ready}); end
        n_vec++; if (o_instr_data !== 32'h00A1_0093) begin n_err++; $display("FAIL fetch_data: got %h want 00a10093", o_instr_data); end
        i_inst_rd_en = 1'b0;
        @(negedge clk);
        i_mem_ready = 1'b0;
        #1;
        n_vec++; if ({o_mem_req, o_instr_ready, o_instr_data} !== 34'd0) begin n_err++; $display("FAIL fetch_idle: got req=%b rdy=%b data=%h want 0", o_mem_req, o_instr_ready, o_instr_data); end
    endtask

    task automatic test_store;
        @(negedge clk);
        i_data_wr_en_ma = 1'b1; i_data_addr = 32'h0000_0100; i_data_wr = 32'h1234_5678; i_data_rd_en_ctrl = 2'b01;
        @(negedge clk);
        n_vec++; if ({o_mem_req, o_mem_we, o_mem_size} !== 4'b1101) begin n_err++; $display("FAIL store_req: got req/we/size %b want 1101", {o_mem_req, o_mem_we, o_mem_size}); end
        n_vec++; if ({o_mem_addr, o_mem_wdata} !== {32'h0000_0100, 32'h1234_5678}) begin n_err++; $display("FAIL store_fields: got %h %h want 00000100 12345678", o_mem_addr, o_mem_wdata); end
        i_mem_ready = 1'b1; i_mem_rdata = 32'h0BAD_0BAD;
        #1;
        n_vec++; if ({o_data_ready, o_instr_ready} !== 2'b10) begin n_err++; $display("FAIL store_ready: got %b want 10", {o_data_ready, o_instr_ready}); end
        i_data_wr_en_ma = 1'b0;
        @(negedge clk);
        i_mem_ready = 1'b0;
        #1;
        n_vec++; if ({o_mem_req, o_data_ready} !== 2'b00) begin n_err++; $display("FAIL store_idle: got %b want 00", {o_mem_req, o_data_ready}); end
    endtask

    task automatic test_size_merge;
        @(negedge clk);
        i_data_rd_en_ma = 1'b1; i_data_wr_en_ma = 1'b1; i_data_rd_en_ctrl = 2'b11;
        i_data_addr = 32'h0000_0500; i_data_wr = 32'hCAFE_F00D;
        @(negedge clk);
        n_vec++; if ({o_mem_we, o_mem_size} !== 3'b110) begin n_err++; $display("FAIL merge_we_size: got %b want 110", {o_mem_we, o_mem_size}); end
        n_vec++; if (o_mem_wdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL merge_wdata: got %h want cafef00d", o_mem_wdata); end
        i_mem_ready = 1'b1;
        #1;
        n_vec++; if (o_data_ready !== 1'b1) begin n_err++; $display("FAIL merge_ready: got %0h want 1", o_data_ready); end
        i_data_rd_en_ma = 1'b0; i_data_wr_en_ma = 1'b0; i_data_rd_en_ctrl = 2'b10;
        @(negedge clk);
        i_mem_ready = 1'b0;
    endtask

    task automatic test_timeout;
        @(negedge clk);
        i_data_rd_en_ma = 1'b1; i_data_addr = 32'h0000_0400; i_mem_rdata = 32'h1111_1111;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_vec++; if ({o_mem_req, o_data_ready, o_timeout} !== 3'b100) begin n_err++; $display("FAIL wd_wait%0d: got %b want 100", k, {o_mem_req, o_data_ready, o_timeout}); end
        end
        @(negedge clk);
        n_vec++; if ({o_mem_req, o_data_ready, o_timeout} !== 3'b111) begin n_err++; $display("FAIL wd_fire: got %b want 111", {o_mem_req, o_data_ready, o_timeout}); end
        n_vec++; if (o_data_rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wd_data: got %h want deadbeef", o_data_rd); end
        i_data_rd_en_ma = 1'b0;
        @(negedge clk);
        n_vec++; if ({o_mem_req, o_timeout} !== 2'b00) begin n_err++; $display("FAIL wd_after: got %b want 00", {o_mem_req, o_timeout}); end
        i_inst_rd_en = 1'b1; i_inst_addr = 32'h0000_0080;
        @(negedge clk);
        i_mem_ready = 1'b1; i_mem_rdata = 32'h0000_0013;
        #1;
        n_vec++; if ({o_instr_ready, o_instr_data, o_timeout} !== {1'b1, 32'h0000_0013, 1'b0}) begin n_err++; $display("FAIL wd_next: got rdy=%b data=%h to=%b want 1 00000013 0", o_instr_ready, o_instr_data, o_timeout); end
        i_inst_rd_en = 1'b0;
        @(negedge clk);
        i_mem_ready = 1'b0;
        i_data_rd_en_ma = 1'b1; i_data_addr = 32'h0000_0404;
        for (int k = 1; k <= 4; k++) @(negedge clk);
        @(negedge clk);
        i_mem_ready = 1'b1; i_mem_rdata = 32'h0000_0055;
        #1;
        n_vec++; if ({o_data_ready, o_data_rd, o_timeout} !== {1'b1, 32'h0000_0055, 1'b0}) begin n_err++; $display("FAIL wd_race: got rdy=%b data=%h to=%b want 1 00000055 0", o_data_ready, o_data_rd, o_timeout); end
        i_data_rd_en_ma = 1'b0;
        @(negedge clk);
        i_mem_ready = 1'b0;
    endtask

    task automatic test_reset_mid_xfer;
        @(negedge clk);
        i_data_wr_en_ma = 1'b1; i_data_addr = 32'h0000_0600; i_data_wr = 32'h0000_0077;
        @(negedge clk);
        n_vec++; if (o_mem_req !== 1'b1) begin n_err++; $display("FAIL mid_req: got %0h want 1", o_mem_req); end
        rst_n = 1'b0; i_mem_ready = 1'b1; i_mem_rdata = 32'h9999_9999;
        #1;
        n_vec++; if ({o_mem_req, o_data_ready, o_instr_ready} !== 3'b000) begin n_err++; $display("FAIL mid_abort: got %b want 000", {o_mem_req, o_data_ready, o_instr_ready}); end
        n_vec++; if (o_data_rd !== 32'd0) begin n_err++; $display("FAIL mid_data: got %h want 0", o_data_rd); end
        rst_n = 1'b1; i_data_wr_en_ma = 1'b0; i_mem_ready = 1'b0;
        @(negedge clk);
        i_inst_rd_en = 1'b1; i_inst_addr = 32'h0000_00C0;
        @(negedge clk);
        n_vec++; if ({o_mem_req, o_mem_we, o_mem_addr} !== {2'b10, 32'h0000_00C0}) begin n_err++; $display("FAIL mid_fetch: got req=%b we=%b addr=%h want 1 0 000000c0", o_mem_req, o_mem_we, o_mem_addr); end
        i_mem_ready = 1'b1; i_mem_rdata = 32'h0000_6F00;
        #1;
        n_vec++; if ({o_instr_ready, o_instr_data} !== {1'b1, 32'h0000_6F00}) begin n_err++; $display("FAIL mid_fetch_done: got %b %h want 1 00006f00", o_instr_ready, o_instr_data); end
        i_inst_rd_en = 1'b0;
        @(negedge clk);
        i_mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_fetch();
        test_store();
        test_size_merge();
        test_timeout();
        test_reset_mid_xfer();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
Shares one single-ported unified memory between the RV32I core's instruction-fetch port and its load/store port. Sits between the core (o_inst_*/i_instr_*, o_data_*/i_data_* buses) and the memory model/controller. One transaction in flight at a time. Fixed or round-robin priority. Watchdog completes stuck transactions.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
TIMEOUT_CYC, 255, max cycles o_mem_req may wait for i_mem_ready; 0 disables the watchdog
TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned on a timed-out access

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_inst_rd_en  in  1  core fetch request, level, held until o_instr_ready
i_inst_addr  in  ADDR_W  fetch address
o_instr_ready  out  1  fetch complete, 1-cycle pulse
o_instr_data  out  DATA_W  fetched word, valid with o_instr_ready
i_data_rd_en_ma  in  1  core load request, level
i_data_wr_en_ma  in  1  core store request, level
i_data_rd_en_ctrl  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
i_data_addr  in  ADDR_W  load/store address
i_data_wr  in  DATA_W  store data
o_data_ready  out  1  load/store complete, 1-cycle pulse
o_data_rd  out  DATA_W  load data, valid with o_data_ready
o_mem_req  out  1  memory request
o_mem_we  out  1  1 = write
o_mem_addr  out  ADDR_W  memory address
o_mem_wdata  out  DATA_W  write data
o_mem_size  out  2  access size (11 mapped to 10)
i_mem_ready  in  1  memory completion for the current request
i_mem_rdata  in  DATA_W  memory read data, valid with i_mem_ready
o_timeout  out  1  1-cycle pulse when the watchdog aborts an access

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; watchdog counter 0; RR pointer = data. Reset mid-transaction abandons the transaction silently.
- FSM states: IDLE, INSTR_XFER, DATA_XFER.
- IDLE: o_mem_req=0. Data request = rd_en_ma|wr_en_ma.
  - Data request only -> DATA_XFER.
  - Fetch only -> INSTR_XFER.
  - Both -> DATA_XFER (fixed priority, see optional feature).
  - On the transition edge, register addr, we (=wr_en_ma), wdata and size. Fetch: we=0, size=10.
  - If rd_en_ma and wr_en_ma are both set, the access is a write.
- XFER states: o_mem_req=1 with the registered fields held stable. Requester inputs are ignored while in XFER.
  - On i_mem_ready=1 the granted side's ready is driven combinationally that cycle. Its data output passes through i_mem_rdata (write completion gives rdata as well; the core ignores it). The FSM returns to IDLE at the next edge.
  - The non-granted side's ready is always 0.
- Latency: request seen in IDLE at cycle N gives o_mem_req at N+1. Completion is at the earliest N+1. Max throughput is one access per 2 cycles.
- After completion the requester must drop or change its request by the next edge. Its level is re-sampled in IDLE, so a still-high request there is a new access.
- Watchdog (TIMEOUT_CYC>0):
  - The counter resets on entry to XFER and increments each XFER cycle without i_mem_ready.
  - When count==TIMEOUT_CYC with no i_mem_ready, the arbiter forces completion. Ready pulses, data=TIMEOUT_DATA, o_timeout=1, o_mem_req stays high that cycle, and the FSM returns to IDLE.
  - If i_mem_ready coincides with the timeout cycle, it is a normal completion with no o_timeout.
  - The counter saturates and never wraps.
- Outputs o_instr_data/o_data_rd are 0 when their ready is 0.

Optional Feature:
RISCV_ARB_RR_EN
- Defined: round-robin on conflict. A 1-bit pointer names the preferred side; it flips to the other side after each granted access.
- Not defined: data always wins conflicts. The pointer logic is absent.

Test Plan:
- Fetch only, addr 0x0000_0040, memory ready 1 cycle after req, rdata 0x00A10093 -> o_mem_req at N+1 with addr 0x40, we=0, size=10; o_instr_ready pulse with data 0x00A10093; FSM back to IDLE.
- Store, addr 0x100, data 0x1234_5678, size 01 -> o_mem_we=1, o_mem_addr=0x100, o_mem_wdata=0x12345678, o_mem_size=01; o_data_ready pulse; o_instr_ready stays 0.
- Fetch and load held together for 4 accesses. Default build: data granted every time it requests. With RISCV_ARB_RR_EN: grants alternate D,I,D,I.
- Memory never asserts ready, TIMEOUT_CYC=4 -> completion 4 cycles after o_mem_req rises; o_data_rd=0xDEADBEEF and o_timeout=1 for one cycle. The next request is accepted normally.
- rst_n pulled low for 1 ns mid DATA_XFER -> o_mem_req and all readies 0 immediately, no completion pulse; after release a fetch proceeds from IDLE.
- rd_en_ma and wr_en_ma both high, size 11 -> o_mem_we=1, o_mem_size=10.
